// File: rtl/dcache_rr_tag_arbiter.sv
// Shared data/tag SRAM arbiter with registered per-way tag compare.
// Port 0 has strict priority, ports 1..NR_PORTS-1 share round-robin; DCACHE_ARB_STARVE_EN bounds port-0 lockout.
module dcache_rr_tag_arbiter #(
   parameter int  NR_PORTS     = 4,
   parameter int  SET_ASSOC    = 8,
   parameter int  ADDR_WIDTH   = 12,
   parameter int  TAG_WIDTH    = 44,
   parameter int  DATA_WIDTH   = 128,
   parameter int  STARVE_LIMIT = 8,
   localparam int LINE_WIDTH   = DATA_WIDTH + TAG_WIDTH + 2,
   localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]   req_i,
   input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
   input  logic [NR_PORTS-1:0][LINE_WIDTH-1:0]  wdata_i,
   input  logic [NR_PORTS-1:0]                  we_i,
   input  logic [NR_PORTS-1:0][BE_WIDTH-1:0]    be_i,
   input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]   tag_i,
   output logic [NR_PORTS-1:0]                  gnt_o,
   output logic [SET_ASSOC-1:0][LINE_WIDTH-1:0] rdata_o,
   output logic [SET_ASSOC-1:0]                 hit_way_o,
   output logic [SET_ASSOC-1:0]                 req_o,
   output logic [ADDR_WIDTH-1:0]                addr_o,
   output logic [LINE_WIDTH-1:0]                wdata_o,
   output logic                                 we_o,
   output logic [BE_WIDTH-1:0]                  be_o,
   input  logic [SET_ASSOC-1:0][LINE_WIDTH-1:0] rdata_i
);

   // cache line layout, MSB first: valid, dirty, tag, data
   localparam int VALID_BIT = LINE_WIDTH - 1;
   localparam int TAG_LSB   = DATA_WIDTH;
   localparam int PW        = $clog2(NR_PORTS);

   if (NR_PORTS < 2 || STARVE_LIMIT < 1) begin : g_bad_params
      $error("dcache_rr_tag_arbiter: NR_PORTS must be >= 2 and STARVE_LIMIT >= 1");
   end

   logic [NR_PORTS-1:0] port_req;
   logic                ctrl_req;
   logic                ctrl_found;
   logic                starve_hit;
   logic                gnt_valid;
   logic [PW-1:0]       rr_win;
   logic [PW-1:0]       win_idx;
   logic [PW-1:0]       rr_q;
   logic [PW-1:0]       id_q;
   logic                rd_q;

   for (genvar g = 0; g < NR_PORTS; g++) begin : g_port_req
      assign port_req[g] = |req_i[g];
   end

   assign ctrl_req = |port_req[NR_PORTS-1:1];

`ifdef DCACHE_ARB_STARVE_EN
   localparam int SCW = $clog2(STARVE_LIMIT + 1);
   logic [SCW-1:0] starve_q;

   assign starve_hit = ctrl_req && (starve_q == SCW'(STARVE_LIMIT));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_q <= '0;
      end else if (!ctrl_req || (gnt_valid && win_idx != '0)) begin
         starve_q <= '0;
      end else if (gnt_valid) begin
         starve_q <= starve_q + 1'b1;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   // round-robin scan over controller ports, starting at rr_q and wrapping back to port 1
   always_comb begin
      int idx;
      idx        = 0;
      ctrl_found = 1'b0;
      rr_win     = '0;
      for (int i = 0; i < NR_PORTS - 1; i++) begin
         idx = int'(rr_q) + i;
         if (idx > NR_PORTS - 1) idx = idx - (NR_PORTS - 1);
         if (!ctrl_found && port_req[PW'(idx)]) begin
            ctrl_found = 1'b1;
            rr_win     = PW'(idx);
         end
      end
   end

   always_comb begin
      gnt_valid = 1'b0;
      win_idx   = '0;
      if (port_req[0] && !starve_hit) begin
         gnt_valid = 1'b1;
      end else if (ctrl_found) begin
         gnt_valid = 1'b1;
         win_idx   = rr_win;
      end
   end

   assign gnt_o   = gnt_valid ? (NR_PORTS'(1) << win_idx) : '0;
   assign req_o   = gnt_valid ? req_i[win_idx] : '0;
   assign we_o    = gnt_valid & we_i[win_idx];
   assign addr_o  = addr_i[win_idx];
   assign wdata_o = wdata_i[win_idx];
   assign be_o    = be_i[win_idx];
   assign rdata_o = rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q <= '0;
         rd_q <= 1'b0;
         rr_q <= PW'(1);
      end else begin
         id_q <= win_idx;
         rd_q <= gnt_valid & ~we_i[win_idx];
         if (gnt_valid && win_idx != '0) begin
            rr_q <= (win_idx == PW'(NR_PORTS - 1)) ? PW'(1) : win_idx + 1'b1;
         end
      end
   end

   // compare tag of the port granted last cycle against the SRAM read data now returning
   for (genvar g = 0; g < SET_ASSOC; g++) begin : g_hit
      assign hit_way_o[g] = rd_q & rdata_i[g][VALID_BIT] &
                            (rdata_i[g][TAG_LSB +: TAG_WIDTH] == tag_i[id_q]);
   end

endmodule

// File: doc/dcache_rr_tag_arbiter.md
# dcache_rr_tag_arbiter

Parametrised successor to the fixed-priority tag-compare/arbitration stage of the non-blocking L1 data cache. Arbitrates NR_PORTS requesters (port 0 = miss handler, ports 1..NR_PORTS-1 = cache controllers) onto the shared data/tag/valid-dirty SRAM bank, and performs registered per-way tag comparison on read data. Port 0 has strict priority. Controller ports share access round-robin, and an optional starvation guard bounds how long port 0 can lock them out. The block sits between the cache controllers/miss handler and the SRAM arrays.

## Interface
Parameters:
- NR_PORTS, 4: number of requesters; ≥2.
- SET_ASSOC, 8: ways.
- ADDR_WIDTH, 12: index+byte-offset width.
- TAG_WIDTH, 44: tag width for comparison.
- STARVE_LIMIT, 8: max consecutive port-0 grants while controller ports wait; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NR_PORTS×SET_ASSOC  per-port way-select request.
- addr_i  in  NR_PORTS×ADDR_WIDTH  per-port address.
- wdata_i  in  NR_PORTS×cache_line_t  write line (data/tag/valid/dirty).
- we_i  in  NR_PORTS  write enable.
- be_i  in  NR_PORTS×cl_be_t  byte enables.
- tag_i  in  NR_PORTS×TAG_WIDTH  compare tag, supplied one cycle after grant.
- gnt_o  out  NR_PORTS  one-hot grant.
- rdata_o  out  SET_ASSOC×cache_line_t  read data, pass-through of rdata_i.
- hit_way_o  out  SET_ASSOC  per-way hit for the previous cycle's read.
- req_o  out  SET_ASSOC  SRAM way request.
- addr_o  out  ADDR_WIDTH  SRAM address.
- wdata_o  out  cache_line_t  SRAM write data.
- we_o  out  1  SRAM write enable.
- be_o  out  cl_be_t  SRAM byte enables.
- rdata_i  in  SET_ASSOC×cache_line_t  SRAM read data (1-cycle latency).

## Operation
- A port requests when |req_i[p]. Exactly one grant per cycle, combinational from current requests and state.
- Selection: port 0 wins if requesting, unless the starvation override is active. Otherwise, scan ports 1..NR_PORTS-1 starting at rr_q and wrapping to 1; the first requester wins.
- The winner's req/addr/wdata/we/be drive the SRAM outputs. With no winner, req_o=0 and we_o=0; the remaining outputs are don't-care but are driven from port 0.
- rr_q: reset 1. After a grant to port k≥1, rr_q ← k+1, or 1 if k=NR_PORTS-1. Unchanged on port-0 grant or idle. For NR_PORTS=2, rr_q is constantly 1.
- Tag compare: id_q ← winner index and rd_q ← (grant & !we) each cycle. hit_way_o[w] = rd_q & rdata_i[w].valid & (rdata_i[w].tag == tag_i[id_q]). hit_way_o may be multi-hot only on corrupted state; not corrected.
- Writes never produce hits; rd_q=0 the cycle after a write or an idle cycle.

## Timing
- Grant: 0 cycles (same cycle as request). Read data/hit: 1 cycle after grant.
- Back-to-back grants to any ports allowed every cycle. A port holds its request until granted.
- Reset values: id_q=0, rd_q=0, rr_q=1, starve_q=0. hit_way_o=0 during and immediately after reset. A read in flight at reset is discarded.
- Simultaneous port-0 and controller requests: port 0 granted, subject to the starvation rule.

## Configuration
- DCACHE_ARB_STARVE_EN defined:
  - starve_q (width $clog2(STARVE_LIMIT+1)) increments on each port-0 grant while any controller port requests.
  - starve_q clears on any controller grant, or on any cycle with no controller request.
  - When starve_q==STARVE_LIMIT and a controller requests, port 0 is denied for that cycle, the round-robin winner is granted, and starve_q clears.
- Undefined: no starve_q; port 0 has absolute priority and can starve controllers indefinitely.

## Test plan
- Single read, port 2, way 3 valid with matching tag → gnt_o=4'b0100 in cycle 0; hit_way_o=8'b0000_1000 in cycle 1.
- Ports 1, 2, 3 request continuously, port 0 idle → grant order 1, 2, 3, 1, 2, 3…; rr_q wraps 3→1.
- Port 0 and port 1 request continuously, STARVE_EN defined, STARVE_LIMIT=8 → 8 port-0 grants, then 1 port-1 grant, repeating. With the macro undefined → port 1 is never granted.
- Write by port 1 followed by a read by port 3 to the same index → no hit the cycle after the write; the read hits with the written tag.
- rst_ni asserted the cycle after a read grant → hit_way_o=0 and rr_q=1; the first grant after reset goes to the lowest requesting controller port.
